fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipeline. It owns the program counter, issues one-outstanding requests to instruction memory, and buffers one returned instruction. It presents the fetched instruction to decode. It consumes `enable_pc` and `enable_if` from the hazard detection unit and takes redirects (`jump_ex`, `jump_target_ex`) from the execute stage.

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with a one-entry fetch buffer and the IF/ID pipeline register.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_pc,
    input  logic        enable_if,
    input  logic        jump_ex,
    input  logic [31:0] jump_target_ex,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic        fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {S_BOOT, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_buf_valid;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_word;
    logic [31:0] r_pc_id;
    logic [31:0] r_instr_id;
    logic        r_valid_id;

    logic        w_rsp;
    logic        w_take_buf;
    logic        w_bypass;
    logic        w_rsp_to_buf;
    logic        w_buf_next;
    logic        w_issue;

    assign w_rsp        = (r_state == S_WAIT) && imem_rvalid;
    assign w_take_buf   = enable_if && r_buf_valid;
    assign w_bypass     = enable_if && !r_buf_valid && w_rsp;
    assign w_rsp_to_buf = w_rsp && !w_bypass;
    // Issue only if the buffer ends this cycle empty, so the next response always has a home.
    assign w_buf_next   = (r_buf_valid && !w_take_buf) || w_rsp_to_buf;
    assign w_issue      = ((r_state == S_ISSUE) || w_rsp) && enable_pc && !jump_ex && !w_buf_next;

    always_comb begin
        w_state_nxt = r_state;
        if (jump_ex) begin
            if (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rvalid)
                w_state_nxt = S_DRAIN;
            else
                w_state_nxt = S_ISSUE;
        end else begin
            case (r_state)
                S_BOOT:  w_state_nxt = S_ISSUE;
                S_ISSUE: if (w_issue) w_state_nxt = S_WAIT;
                S_WAIT:  if (w_rsp) w_state_nxt = w_issue ? S_WAIT : S_ISSUE;
                S_DRAIN: if (imem_rvalid) w_state_nxt = S_ISSUE;
                default: w_state_nxt = S_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (jump_ex)
                r_pc <= jump_target_ex & 32'hFFFF_FFFC;
            else if (w_issue)
                r_pc <= r_pc + 32'd4;
            if (w_issue)
                r_req_pc <= r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_pc    <= '0;
            r_buf_word  <= '0;
        end else if (jump_ex) begin
            r_buf_valid <= 1'b0;
        end else if (w_rsp_to_buf) begin
            r_buf_valid <= 1'b1;
            r_buf_pc    <= r_req_pc;
            r_buf_word  <= imem_rdata;
        end else if (w_take_buf) begin
            r_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_id    <= '0;
            r_instr_id <= NOP_INSTR;
            r_valid_id <= 1'b0;
        end else if (jump_ex) begin
            r_instr_id <= NOP_INSTR;
            r_valid_id <= 1'b0;
        end else if (enable_if) begin
            if (r_buf_valid) begin
                r_pc_id    <= r_buf_pc;
                r_instr_id <= r_buf_word;
                r_valid_id <= 1'b1;
            end else if (w_rsp) begin
                r_pc_id    <= r_req_pc;
                r_instr_id <= imem_rdata;
                r_valid_id <= 1'b1;
            end else begin
                r_instr_id <= NOP_INSTR;
                r_valid_id <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_rsp && !jump_ex)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (!enable_if && r_valid_id)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`else
    // Counters absent in this build.
`endif

    assign imem_req   = w_issue;
    assign imem_addr  = r_pc;
    assign pc_id      = r_pc_id;
    assign instr_id   = r_instr_id;
    assign valid_id   = r_valid_id;
    assign fetch_busy = (r_state == S_WAIT) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns the inverted address as data.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_pc = 1'b1;
    logic        enable_if = 1'b1;
    logic        jump_ex = 1'b0;
    logic [31:0] jump_target_ex = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        fetch_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat = 1;
    int m_cnt;
    logic [31:0] m_addr;

    fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .enable_pc(enable_pc), .enable_if(enable_if),
        .jump_ex(jump_ex), .jump_target_ex(jump_target_ex),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_id(pc_id), .instr_id(instr_id), .valid_id(valid_id), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory with mem_lat cycles between request and response.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt       <= 0;
            m_addr      <= '0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req) begin
                if (mem_lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= ~imem_addr;
                end else begin
                    m_cnt  <= mem_lat - 1;
                    m_addr <= imem_addr;
                end
            end else if (m_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= ~m_addr;
                m_cnt       <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst_n = 1'b0;
        enable_pc = 1'b1;
        enable_if = 1'b1;
        jump_ex = 1'b0;
        jump_target_ex = '0;
        mem_lat = lat;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got %0h exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'h100) begin n_errors++; $display("FAIL reset_addr got %h exp 00000100", imem_addr); end
        n_checks++; if (pc_id !== 32'h0) begin n_errors++; $display("FAIL reset_pc_id got %h exp 0", pc_id); end
        n_checks++; if (instr_id !== 32'h13) begin n_errors++; $display("FAIL reset_instr got %h exp 00000013", instr_id); end
        n_checks++; if (valid_id !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0h exp 0", valid_id); end
        n_checks++; if (fetch_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0h exp 0", fetch_busy); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        do_reset(1);
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL boot_req got %0h exp 0", imem_req); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h100 + 32'(4 * c)) begin
                n_errors++;
                $display("FAIL stream_req c%0d got req=%0h addr=%h exp req=1 addr=%h", c, imem_req, imem_addr, 32'h100 + 32'(4 * c));
            end
            if (c >= 2) begin
                exp_pc = 32'h100 + 32'(4 * (c - 2));
                n_checks++;
                if (valid_id !== 1'b1 || pc_id !== exp_pc || instr_id !== ~exp_pc) begin
                    n_errors++;
                    $display("FAIL stream_id c%0d got v=%0h pc=%h ins=%h exp v=1 pc=%h ins=%h", c, valid_id, pc_id, instr_id, exp_pc, ~exp_pc);
                end
            end else begin
                n_checks++;
                if (valid_id !== 1'b0) begin n_errors++; $display("FAIL stream_lat c%0d got v=%0h exp 0", c, valid_id); end
            end
        end
    endtask

    task automatic test_stall;
        logic        exp_req [0:10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] exp_addr [0:10] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0, 32'h0,
                                         32'h110, 32'h114, 32'h118, 32'h11C};
        logic [31:0] exp_pcid [0:10] = '{32'h0, 32'h0, 32'h100, 32'h104, 32'h108, 32'h108, 32'h108,
                                         32'h108, 32'h10C, 32'h110, 32'h114};
        do_reset(1);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            enable_if = !(c >= 4 && c <= 6);
            #1;
            n_checks++;
            if (imem_req !== exp_req[c] || (exp_req[c] && imem_addr !== exp_addr[c])) begin
                n_errors++;
                $display("FAIL stall_req c%0d got req=%0h addr=%h exp req=%0h addr=%h", c, imem_req, imem_addr, exp_req[c], exp_addr[c]);
            end
            if (c >= 2) begin
                n_checks++;
                if (valid_id !== 1'b1 || pc_id !== exp_pcid[c] || instr_id !== ~exp_pcid[c]) begin
                    n_errors++;
                    $display("FAIL stall_id c%0d got v=%0h pc=%h ins=%h exp v=1 pc=%h", c, valid_id, pc_id, instr_id, exp_pcid[c]);
                end
            end
        end
        enable_if = 1'b1;
    endtask

    task automatic test_jump_drain;
        do_reset(3);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            jump_ex = (c == 4);
            jump_target_ex = (c == 4) ? 32'h0000_2003 : 32'h0;
            #1;
            if (c == 0 || c == 3) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== ((c == 0) ? 32'h100 : 32'h104)) begin
                    n_errors++; $display("FAIL jd_req c%0d got req=%0h addr=%h", c, imem_req, imem_addr);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (imem_req !== 1'b0 || valid_id !== 1'b1 || pc_id !== 32'h100) begin
                    n_errors++; $display("FAIL jd_jump got req=%0h v=%0h pc=%h exp req=0 v=1 pc=00000100", imem_req, valid_id, pc_id);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (valid_id !== 1'b0 || instr_id !== 32'h13 || pc_id !== 32'h100 || fetch_busy !== 1'b1 || imem_req !== 1'b0) begin
                    n_errors++;
                    $display("FAIL jd_bubble got v=%0h ins=%h pc=%h busy=%0h req=%0h exp v=0 ins=13 pc=100 busy=1 req=0", valid_id, instr_id, pc_id, fetch_busy, imem_req);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (imem_req !== 1'b0 || fetch_busy !== 1'b1) begin n_errors++; $display("FAIL jd_drain got req=%0h busy=%0h exp req=0 busy=1", imem_req, fetch_busy); end
            end
            if (c == 7) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || valid_id !== 1'b0 || fetch_busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL jd_target got req=%0h addr=%h v=%0h busy=%0h exp req=1 addr=00002000 v=0 busy=0", imem_req, imem_addr, valid_id, fetch_busy);
                end
            end
            if (c == 11) begin
                n_checks++;
                if (valid_id !== 1'b1 || pc_id !== 32'h2000 || instr_id !== 32'hFFFF_DFFF) begin
                    n_errors++; $display("FAIL jd_arrive got v=%0h pc=%h ins=%h exp v=1 pc=00002000 ins=ffffdfff", valid_id, pc_id, instr_id);
                end
            end
        end
    endtask

    task automatic test_jump_rvalid;
        do_reset(1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            jump_ex = (c == 2);
            jump_target_ex = (c == 2) ? 32'h0000_3000 : 32'h0;
            #1;
            if (c == 2) begin
                n_checks++;
                if (imem_req !== 1'b0 || valid_id !== 1'b1 || pc_id !== 32'h100) begin
                    n_errors++; $display("FAIL jr_jump got req=%0h v=%0h pc=%h exp req=0 v=1 pc=00000100", imem_req, valid_id, pc_id);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || valid_id !== 1'b0 || fetch_busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL jr_target got req=%0h addr=%h v=%0h busy=%0h exp req=1 addr=00003000 v=0 busy=0", imem_req, imem_addr, valid_id, fetch_busy);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h3004 || valid_id !== 1'b0) begin
                    n_errors++; $display("FAIL jr_drop got req=%0h addr=%h v=%0h exp req=1 addr=00003004 v=0", imem_req, imem_addr, valid_id);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (valid_id !== 1'b1 || pc_id !== 32'h3000 || instr_id !== 32'hFFFF_CFFF) begin
                    n_errors++; $display("FAIL jr_arrive got v=%0h pc=%h ins=%h exp v=1 pc=00003000 ins=ffffcfff", valid_id, pc_id, instr_id);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            enable_if = !(c >= 4);
        end
        #1;
        n_checks++;
        if (pc_id !== 32'h108 || valid_id !== 1'b1) begin n_errors++; $display("FAIL rm_pre got v=%0h pc=%h exp v=1 pc=00000108", valid_id, pc_id); end
        rst_n = 1'b0;
        enable_if = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100 || pc_id !== 32'h0 || instr_id !== 32'h13 || valid_id !== 1'b0 || fetch_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL rm_async got req=%0h addr=%h pc=%h ins=%h v=%0h busy=%0h", imem_req, imem_addr, pc_id, instr_id, valid_id, fetch_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL rm_boot got req=%0h exp 0", imem_req); end
        @(negedge clk); #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_errors++; $display("FAIL rm_restart got req=%0h addr=%h exp req=1 addr=00000100", imem_req, imem_addr); end
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (valid_id !== 1'b1 || pc_id !== 32'h100 || instr_id !== 32'hFFFF_FEFF) begin
            n_errors++; $display("FAIL rm_first got v=%0h pc=%h ins=%h exp v=1 pc=00000100 ins=fffffeff", valid_id, pc_id, instr_id);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf;
        do_reset(1);
        #1;
        n_checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            n_errors++; $display("FAIL perf_reset got f=%0d s=%0d exp 0 0", perf_fetch_cnt, perf_stall_cnt);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            enable_if = !(c >= 3 && c <= 6);
            enable_pc = (c < 14);
        end
        #1;
        n_checks++;
        if (perf_fetch_cnt !== 32'd10) begin n_errors++; $display("FAIL perf_fetch got %0d exp 10", perf_fetch_cnt); end
        n_checks++;
        if (perf_stall_cnt !== 32'd4) begin n_errors++; $display("FAIL perf_stall got %0d exp 4", perf_stall_cnt); end
        enable_pc = 1'b1;
        enable_if = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout exp completion before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump_drain();
        test_jump_rvalid();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
